sort_arbiter: RTL

SORT_ARBITER -- requirements
Module: sort_arbiter

---
 rtl/sort_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/sort_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the sort arbiter slice.
// Holds the default sizing, the default sequence/requester-id types and a
// helper that gives a safe id width even for a single requester.
package sort_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_FIFO_DEPTH = 8;

    // Width of a requester index; never zero so single-requester builds work.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

    typedef logic [DEF_DEPTH-1:0][DEF_WIDTH-1:0] seq_t;
    typedef logic [DEF_ID_W-1:0]                 req_id_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, data_i  : write request and data (taken when not full, or when
//                     a pop happens in the same cycle)
//   pop_i           : read request (ignored when empty)
//   data_o          : head entry, forced to zero while empty
//   empty_o         : no entries stored
//   count_o         : number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // A pop frees the slot the same cycle, so push-while-full is lossless
    // when paired with a pop.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the output is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sort_arbiter.sv
// Round-robin front end sharing one fixed-latency sorter among NUM_REQ
// requesters, with in-order tagged responses.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready/req_data : per-requester sequence handshake
//   sort_valid_o/sort_data_o   : registered issue to the external sorter
//   sort_valid_i/sort_data_i   : sorter results (in order, never stalled)
//   rsp_valid/rsp_ready/rsp_id/rsp_data : response queue head and handshake
//   err_o                      : sticky, result arrived with nothing in flight
module sort_arbiter
    import sort_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int IDW        = id_width(NUM_REQ)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ-1:0][DEPTH-1:0][WIDTH-1:0]   req_data,
    output logic                                       sort_valid_o,
    output logic [DEPTH-1:0][WIDTH-1:0]                sort_data_o,
    input  logic                                       sort_valid_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]                sort_data_i,
    output logic                                       rsp_valid,
    input  logic                                       rsp_ready,
    output logic [IDW-1:0]                             rsp_id,
    output logic [DEPTH-1:0][WIDTH-1:0]                rsp_data,
    output logic                                       err_o
);

    localparam int DW = DEPTH * WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [IDW-1:0]    last_q;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_found;
    logic              credit_ok;
    logic              accept;
    logic              ret_ok;
    logic              sort_valid_q;
    logic [DW-1:0]     sort_data_q;
    logic              err_q, err_d;

    logic [IDW-1:0]    tag_head;
    logic              tag_empty;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     rsp_count;
    logic              rsp_empty;
    logic [IDW+DW-1:0] rsp_word;
    logic [CW:0]       occ_sum;

    // Round-robin search starting just after the last grant.
    always_comb begin
        int c;
        c         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = int'(last_q) + 1 + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!gnt_found && req_valid[IDW'(c)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(c);
            end
        end
    end

    // Credits cover both sequences inside the sorter and those waiting in
    // the response queue, so a sorter result always has a slot to land in.
    assign occ_sum   = {1'b0, in_flight} + {1'b0, rsp_count};
    assign credit_ok = occ_sum < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        req_ready = '0;
        if (rst_n && gnt_found && credit_ok) req_ready[gnt_idx] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);
    assign ret_ok = sort_valid_i && !tag_empty;
    assign err_d  = err_q | (sort_valid_i & tag_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sort_valid_q <= 1'b0;
            sort_data_q  <= '0;
            last_q       <= IDW'(NUM_REQ - 1);
            err_q        <= 1'b0;
        end else begin
            sort_valid_q <= accept;
            err_q        <= err_d;
            if (accept) begin
                sort_data_q <= req_data[gnt_idx];
                last_q      <= gnt_idx;
            end
        end
    end

    // Tag queue: its occupancy is the in-flight count.
    sync_fifo #(
        .W     (IDW),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .data_i  (gnt_idx),
        .pop_i   (ret_ok),
        .data_o  (tag_head),
        .empty_o (tag_empty),
        .count_o (in_flight)
    );

    sync_fifo #(
        .W     (IDW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ret_ok),
        .data_i  ({tag_head, sort_data_i}),
        .pop_i   (rsp_ready),
        .data_o  (rsp_word),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    assign sort_valid_o = sort_valid_q;
    assign sort_data_o  = sort_data_q;
    assign rsp_valid    = !rsp_empty;
    assign rsp_id       = rsp_word[IDW+DW-1 -: IDW];
    assign rsp_data     = rsp_word[DW-1:0];
    assign err_o        = err_q;

endmodule
